// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux4_arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  // Arbiter FSM: either nobody owns the mux or exactly one requester does.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot vector with bit idx set.
  function automatic logic [N_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant/select bundle between the requesters and the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until granted; no other stall path.
interface mux4_arb_if;
  import mux4_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic             s1;
  logic             s0;
  logic             busy;

  // Requester side drives req and observes the grant and mux select.
  modport master (output req, input grant, s1, s0, busy);
  // Arbiter side.
  modport slave  (input req, output grant, s1, s0, busy);

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin search: first set req bit after ptr, wrapping 3->0.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; any=0 when no bit is set.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win,
  output logic             any
);

  // Walk from the lowest-priority slot (ptr itself) up to ptr+1 so the nearest hit overwrites.
  always_comb begin
    win = ptr;
    any = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[ptr + IDX_W'(k)]) begin
        win = ptr + IDX_W'(k);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of the shared 4:1 mux; drives one-hot grant and {s1,s0} select.
// Latency: req in cycle N -> grant/select in cycle N+1, handover without idle bubble.
// Backpressure: owner keeps the mux while requesting, forced off after MAX_HOLD if others wait.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
)
(
  input logic       clk,
  input logic       rst,
  mux4_arb_if.slave arb
);

  localparam int               CNT_W    = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  state_t             state_q,    state_d;
  logic [IDX_W-1:0]   last_ptr_q, last_ptr_d;
  logic [IDX_W-1:0]   sel_q,      sel_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]   grant_q,    grant_d;

  logic [N_REQ-1:0]   pick_req;
  logic [IDX_W-1:0]   pick_win;
  logic               pick_any;
  logic               owner_req;

  // The owner is always masked out of the search while granted: if it dropped
  // it is already zero, and on a forced rotation it must be skipped.
  assign pick_req  = (state_q == GRANT) ? (arb.req & ~onehot4(last_ptr_q)) : arb.req;
  assign owner_req = arb.req[last_ptr_q];

  rr_pick4 u_pick (
    .req (pick_req),
    .ptr (last_ptr_q),
    .win (pick_win),
    .any (pick_any)
  );

  // Next-state: new grant, hold, forced rotation or release to idle.
  always_comb begin
    state_d    = state_q;
    last_ptr_d = last_ptr_q;
    sel_d      = sel_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = GRANT;
          last_ptr_d = pick_win;
          sel_d      = pick_win;
          grant_d    = onehot4(pick_win);
          hold_cnt_d = HOLD_ONE;
        end
      end
      GRANT: begin
        if (!owner_req || (hold_cnt_q == HOLD_MAX)) begin
          if (pick_any) begin
            last_ptr_d = pick_win;
            sel_d      = pick_win;
            grant_d    = onehot4(pick_win);
            hold_cnt_d = HOLD_ONE;
          end else if (!owner_req) begin
            // Nobody left: release, but keep sel so the mux output stays put.
            state_d    = IDLE;
            grant_d    = '0;
            hold_cnt_d = '0;
          end else begin
            // Cap reached with no contenders: silently restart the hold window.
            hold_cnt_d = HOLD_ONE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and registered outputs; reset leaves requester 0 with first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_ptr_q <= IDX_W'(N_REQ - 1);
      sel_q      <= '0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_ptr_q <= last_ptr_d;
      sel_q      <= sel_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
    end
  end

  assign arb.grant = grant_q;
  assign arb.s1    = sel_q[1];
  assign arb.s0    = sel_q[0];
  assign arb.busy  = (state_q == GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios with literal expectations, then random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_mux4_rr_arbiter;

  localparam int MH = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  mux4_arb_if bus ();

  mux4_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the mux, how long, and where the search resumes.
  bit       m_valid = 1'b0;
  bit       m_owned;
  int       m_owner;
  int       m_last;
  int       m_hold;
  int       m_sel;

  function automatic int next_after(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++)
      if (r[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [3:0] others;
    int w;
    if (rst) begin
      m_valid = 1'b1;
      m_owned = 1'b0;
      m_last  = 3;
      m_sel   = 0;
      m_hold  = 0;
    end else if (m_valid) begin
      if (!m_owned) begin
        w = next_after(bus.req, m_last);
        if (w >= 0) begin
          m_owned = 1'b1; m_owner = w; m_last = w; m_sel = w; m_hold = 1;
        end
      end else begin
        others = bus.req;
        others[m_owner] = 1'b0;
        w = next_after(others, m_last);
        if (bus.req[m_owner] && m_hold < MH) begin
          m_hold++;
        end else if (w >= 0) begin
          m_owner = w; m_last = w; m_sel = w; m_hold = 1;
        end else if (bus.req[m_owner]) begin
          m_hold = 1;
        end else begin
          m_owned = 1'b0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    logic [3:0] eg;
    if (m_valid) begin
      eg = m_owned ? 4'(1 << m_owner) : 4'b0000;
      check("grant", bus.grant, eg);
      check("sel", {bus.s1, bus.s0}, m_sel);
      check("busy", bus.busy, m_owned);
      check("grant_onehot0", $onehot0(bus.grant), 1);
    end
  end

  task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] s, input logic b);
    check({name, "_grant"}, bus.grant, g);
    check({name, "_sel"}, {bus.s1, bus.s0}, s);
    check({name, "_busy"}, bus.busy, b);
  endtask

  initial begin
    logic [3:0] e;
    logic [3:0] r;
    rst     = 1'b1;
    bus.req = 4'hF;

    // Reset with every requester active, then release: requester 0 goes first.
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_out("reset", 4'b0000, 2'b00, 1'b0);
    rst = 1'b0;

    // Saturation: 8 cycles per owner, 0,1,2,3,0, no gaps.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      e = 4'(1 << ((k / 8) % 4));
      check("saturate", bus.grant, e);
    end

    // Everyone leaves: idle, select stays at last owner (0).
    bus.req = 4'b0000;
    @(negedge clk);
    expect_out("drain", 4'b0000, 2'b00, 1'b0);

    // Lone requester 2, held well past the cap.
    bus.req = 4'b0100;
    @(negedge clk);
    expect_out("single", 4'b0100, 2'b10, 1'b1);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      expect_out("hog", 4'b0100, 2'b10, 1'b1);
    end
    bus.req = 4'b0000;
    @(negedge clk);
    expect_out("release", 4'b0000, 2'b10, 1'b0);

    // Handover from 1 to 3 with no idle cycle.
    bus.req = 4'b0010;
    @(negedge clk);
    expect_out("own1", 4'b0010, 2'b01, 1'b1);
    bus.req = 4'b1010;
    @(negedge clk);
    expect_out("own1_hold", 4'b0010, 2'b01, 1'b1);
    bus.req = 4'b1000;
    @(negedge clk);
    expect_out("handover", 4'b1000, 2'b11, 1'b1);

    // Reset in the middle of a grant to requester 2.
    bus.req = 4'b0100;
    @(negedge clk);
    expect_out("own2", 4'b0100, 2'b10, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    expect_out("mid_reset", 4'b0000, 2'b00, 1'b0);
    rst = 1'b0;
    bus.req = 4'b0101;
    @(negedge clk);
    expect_out("post_reset", 4'b0001, 2'b00, 1'b1);

    // Random traffic with sticky requests and rare resets.
    r = bus.req;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 199) == 0) r = 4'hF;
      bus.req = r;
      rst = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
